// File: rtl/temp_sensor_reader_if.sv
// Signal bundle between the temperature reader, the Pmod sensor pins and
// the indicator logic. The reader drives through the master modport.
// Handshake: valid is a one-cycle strobe with no ready; temp and sw_code are
// already stable in the valid cycle and hold until the next completed read,
// so a consumer may sample them on the strobe or at any later time.
interface temp_sensor_reader_if;
  logic       trigger;
  logic       miso;
  logic       cs_n;
  logic       sclk;
  logic [7:0] temp;
  logic [3:0] sw_code;
  logic       valid;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    input  trigger, miso,
    output cs_n, sclk, temp, sw_code, valid, busy, dbg_state
  );

  modport slave (
    output trigger, miso,
    input  cs_n, sclk, temp, sw_code, valid, busy, dbg_state
  );
endinterface

// File: rtl/temp_sensor_reader.sv
// Periodic / on-demand reader for an SPI-style temperature sensor. Each read
// is turned into the 4-bit A/B/C/D condition code with per-bit hysteresis so
// the indicator does not chatter around a threshold.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 2,
  parameter int DATA_BITS     = 8,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int T0            = 20,
  parameter int T1            = 25,
  parameter int T2            = 30,
  parameter int T3            = 40,
  parameter int HYST          = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  temp_sensor_reader_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
  // Keeps only the bits shifted in during one read (zero-extends short reads).
  localparam logic [7:0]       DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             sclk_q, sclk_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       temp_q, temp_d;
  logic [3:0]       code_q, code_d;
  logic [8:0]       reading;

  // Set at or above the threshold, clear below threshold-HYST (saturating
  // at zero, so a threshold <= HYST never clears), otherwise hold.
  function automatic logic code_bit(input logic [8:0] r, input int t,
                                    input logic prev);
    logic [8:0] hi;
    logic [8:0] lo;
    hi = 9'(t);
    lo = (t > HYST) ? 9'(t - HYST) : 9'd0;
    if (r >= hi) begin
      code_bit = 1'b1;
    end else if (r < lo) begin
      code_bit = 1'b0;
    end else begin
      code_bit = prev;
    end
  endfunction

  // State register and datapath flops; reset aborts any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      sclk_q  <= 1'b0;
      shift_q <= '0;
      temp_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      sclk_q  <= sclk_d;
      shift_q <= shift_d;
      temp_q  <= temp_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic: sample timer, sclk phase counting, MSB-first shift and
  // the result/code update on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    timer_d = timer_q;
    sclk_d  = sclk_q;
    shift_d = shift_q;
    temp_d  = temp_q;
    code_d  = code_q;
    reading = {1'b0, shift_q & DATA_MASK};

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q + TMR_W'(1);
        // Timer expiry and trigger in the same cycle still start one read.
        if (bus.trigger || (timer_q == TMR_LAST)) begin
          state_d = S_SETUP;
          timer_d = '0;
          div_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], bus.miso};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d   = S_DONE;
            temp_d    = reading[7:0];
            code_d[0] = code_bit(reading, T0, code_q[0]);
            code_d[1] = code_bit(reading, T1, code_q[1]);
            code_d[2] = code_bit(reading, T2, code_q[2]);
            code_d[3] = code_bit(reading, T3, code_q[3]);
          end else begin
            bit_d   = bit_q + 4'd1;
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], bus.miso};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin-level outputs are decoded from registered state only.
  assign bus.cs_n      = !((state_q == S_SETUP) || (state_q == S_SHIFT));
  assign bus.sclk      = sclk_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.valid     = (state_q == S_DONE);
  assign bus.temp      = temp_q;
  assign bus.sw_code   = code_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: a sensor model serves bytes on miso, a
// scoreboard queue holds the expected {code, temp} per read, and a monitor
// pops and compares on every valid strobe.
module tb_temp_sensor_reader;
  localparam int CLK_DIV       = 2;
  localparam int DATA_BITS     = 8;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int HYST          = 2;
  localparam int TXN_LEN       = CLK_DIV * (1 + 2 * DATA_BITS);

  logic clk = 1'b0;
  logic reset;

  temp_sensor_reader_if bus_if();

  temp_sensor_reader #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .T0(20), .T1(25), .T2(30), .T3(40), .HYST(HYST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  logic [7:0]  sensor_q[$];
  logic [3:0]  model_code = 4'b0000;
  int checks    = 0;
  int fails     = 0;
  int valid_cnt = 0;
  int txn_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: thresholds as plain integers; a negative clear level
  // simply never matches, which gives the saturating behaviour.
  function automatic logic [3:0] model_next(input int r, input logic [3:0] prev);
    int th[4];
    logic [3:0] c;
    th = '{20, 25, 30, 40};
    c  = prev;
    for (int n = 0; n < 4; n++) begin
      if (r >= th[n]) c[n] = 1'b1;
      else if (r < th[n] - HYST) c[n] = 1'b0;
    end
    return c;
  endfunction

  // ---------------- sensor model ----------------
  logic       sens_active = 1'b0;
  logic       sens_prev_sclk = 1'b0;
  int         sens_rises = 0;
  int         sens_low = 0;
  logic [7:0] sens_byte = 8'h00;

  always @(negedge clk) begin
    logic [3:0] e_code;
    if (reset) begin
      sens_active    = 1'b0;
      sens_prev_sclk = 1'b0;
      exp_q.delete();
      model_code     = 4'b0000;
      bus_if.miso    = 1'b0;
    end else begin
      if (!bus_if.cs_n && !sens_active) begin
        sens_active    = 1'b1;
        sens_rises     = 0;
        sens_low       = 0;
        sens_prev_sclk = 1'b0;
        txn_cnt++;
        if (sensor_q.size() > 0) sens_byte = sensor_q.pop_front();
        else sens_byte = 8'($urandom_range(0, 255));
        e_code     = model_next(int'(sens_byte), model_code);
        model_code = e_code;
        exp_q.push_back({e_code, sens_byte});
      end
      if (sens_active) begin
        if (!bus_if.cs_n) begin
          sens_low++;
          if (bus_if.sclk && !sens_prev_sclk) sens_rises++;
        end else begin
          check("cs_low_cycles", sens_low, TXN_LEN);
          check("sclk_rises", sens_rises, DATA_BITS);
          sens_active = 1'b0;
        end
      end
      sens_prev_sclk = bus_if.sclk;
      bus_if.miso = (sens_active && sens_rises < 8) ? sens_byte[7 - sens_rises] : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] prev_code = 4'b0000;

  always @(negedge clk) begin
    logic [11:0] e;
    if (reset) begin
      prev_code = 4'b0000;
    end else begin
      if (bus_if.cs_n) check("sclk_idle_low", bus_if.sclk, 0);
      if (bus_if.valid) begin
        valid_cnt++;
        check("busy_in_done", bus_if.busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_temp", bus_if.temp, e[7:0]);
          check("sb_code", bus_if.sw_code, e[11:8]);
        end
      end else begin
        check("code_stable", bus_if.sw_code, prev_code);
      end
      prev_code = bus_if.sw_code;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_trigger();
    bus_if.trigger = 1'b1;
    @(posedge clk); #1;
    bus_if.trigger = 1'b0;
  endtask

  task automatic wait_valid(input int v_before);
    for (int i = 0; i < 200 && valid_cnt <= v_before; i++) begin
      @(posedge clk); #1;
    end
    check("valid_seen", int'(valid_cnt > v_before), 1);
  endtask

  task automatic wait_cs_low(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (!bus_if.cs_n) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] b, input logic [3:0] exp_code,
                         input bit check_spec);
    int v0;
    sensor_q.push_back(b);
    v0 = valid_cnt;
    pulse_trigger();
    wait_valid(v0);
    if (check_spec) begin
      check("spec_temp", bus_if.temp, b);
      check("spec_code", bus_if.sw_code, exp_code);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, v0, t0, rises;
    logic prev_sclk;
    logic [7:0] spec_bytes[9];
    logic [3:0] spec_codes[9];
    logic [7:0] rb;

    bus_if.trigger = 1'b0;
    do_reset(3);
    check("rst_cs_n", bus_if.cs_n, 1);
    check("rst_sclk", bus_if.sclk, 0);
    check("rst_temp", bus_if.temp, 0);
    check("rst_code", bus_if.sw_code, 0);
    check("rst_valid", bus_if.valid, 0);
    check("rst_busy", bus_if.busy, 0);

    // First automatic read after reset release.
    wait_cs_low(SAMPLE_PERIOD + 100, k);
    check("first_auto_start", k, SAMPLE_PERIOD);
    check("busy_in_setup", bus_if.busy, 1);
    v0 = valid_cnt;
    wait_valid(v0);

    // Next automatic read counted from the edge leaving DONE.
    wait_cs_low(SAMPLE_PERIOD + 100, k);
    check("auto_period_after_done", k, SAMPLE_PERIOD);
    v0 = valid_cnt;
    wait_valid(v0);

    // Trigger coinciding with timer expiry: exactly one read.
    repeat (SAMPLE_PERIOD - 1) begin
      @(posedge clk); #1;
    end
    check("no_early_start", bus_if.cs_n, 1);
    t0 = txn_cnt;
    v0 = valid_cnt;
    pulse_trigger();
    check("start_on_coincidence", bus_if.cs_n, 0);
    repeat (150) begin
      @(posedge clk); #1;
    end
    check("coincide_txns", txn_cnt - t0, 1);
    check("coincide_valids", valid_cnt - v0, 1);

    // Spec sequence from a freshly reset code.
    do_reset(3);
    spec_bytes = '{8'h1E, 8'd30, 8'd29, 8'd27, 8'd22, 8'd17, 8'd42, 8'hFF, 8'h00};
    // 22 lies below 25-2, so B clears while A (>= 20) stays set.
    spec_codes = '{4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0001, 4'b0000,
                   4'b1111, 4'b1111, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      do_read(spec_bytes[i], spec_codes[i], 1'b1);
      repeat (2) @(posedge clk);
      #1;
    end

    // Trigger during SHIFT is ignored and not queued.
    t0 = txn_cnt;
    v0 = valid_cnt;
    sensor_q.push_back(8'd33);
    pulse_trigger();
    repeat (12) begin
      @(posedge clk); #1;
    end
    pulse_trigger();
    repeat (150) begin
      @(posedge clk); #1;
    end
    check("shift_trig_txns", txn_cnt - t0, 1);
    check("shift_trig_valids", valid_cnt - v0, 1);

    // Randomised reads, biased around the thresholds.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) rb = 8'($urandom_range(12, 46));
      else rb = 8'($urandom_range(0, 255));
      do_read(rb, 4'b0000, 1'b0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    // Reset after the 4th sclk rise aborts the read.
    do_read(8'd42, 4'b1111, 1'b1);
    sensor_q.push_back(8'hAB);
    pulse_trigger();
    rises = 0;
    prev_sclk = bus_if.sclk;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      @(posedge clk); #1;
      if (bus_if.sclk && !prev_sclk) rises++;
      prev_sclk = bus_if.sclk;
    end
    check("rises_before_reset", rises, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", bus_if.cs_n, 1);
    check("abort_sclk", bus_if.sclk, 0);
    check("abort_temp", bus_if.temp, 0);
    check("abort_code", bus_if.sw_code, 0);
    check("abort_valid", bus_if.valid, 0);
    reset = 1'b0;
    v0 = valid_cnt;
    repeat (60) begin
      @(posedge clk); #1;
    end
    check("no_valid_after_abort", valid_cnt - v0, 0);
    do_read(8'h1E, 4'b0111, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
